// File: rtl/theta_stage.sv
// ============================================================================
// theta_stage : Keccak-f theta step over a 64-slice streamed state (load, then emit)
// Revision    : 1.0
// ============================================================================
`default_nettype none

module theta_stage #(
  parameter int SLICES = 64,
  parameter int IDX_W  = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [24:0]      in_slice,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [24:0]      out_slice,
  output logic [IDX_W-1:0] out_index,
  output logic             done
);

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    EMIT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SLICES - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] in_cnt_q, in_cnt_d;
  logic [IDX_W-1:0] out_cnt_q, out_cnt_d;
  logic             wr_en;
  logic [4:0]       wr_par;
  logic [24:0]      cur_slice;
  logic [4:0]       par_cur, par_prev;

  logic [24:0] slice_mem [SLICES];
  logic [4:0]  par_q     [SLICES];

  // Column parity of the incoming slice, indexed by x
  for (genvar x = 0; x < 5; x++) begin : g_par
    assign wr_par[x] = in_slice[24-x] ^ in_slice[19-x] ^ in_slice[14-x]
                     ^ in_slice[9-x]  ^ in_slice[4-x];
  end

  assign cur_slice = slice_mem[out_cnt_q];
  assign par_cur   = par_q[out_cnt_q];
  assign par_prev  = par_q[out_cnt_q - IDX_W'(1)];

  for (genvar y = 0; y < 5; y++) begin : g_row
    for (genvar x = 0; x < 5; x++) begin : g_col
      assign out_slice[24-(5*y+x)] = cur_slice[24-(5*y+x)]
                                   ^ par_cur[(x+4)%5] ^ par_prev[(x+1)%5];
    end
  end

  assign out_index = out_cnt_q;

  always_comb begin
    state_d   = state_q;
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    done      = 1'b0;
    wr_en     = 1'b0;
    case (state_q)
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          wr_en    = 1'b1;
          in_cnt_d = in_cnt_q + IDX_W'(1);
          if (in_cnt_q == LAST_IDX) begin
            state_d  = EMIT;
            in_cnt_d = '0;
          end
        end
      end
      EMIT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          out_cnt_d = out_cnt_q + IDX_W'(1);
          if (out_cnt_q == LAST_IDX) begin
            state_d   = DONE;
            out_cnt_d = '0;
          end
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = LOAD;
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= LOAD;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      for (int i = 0; i < SLICES; i++) par_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      if (wr_en) par_q[in_cnt_q] <= wr_par;
    end
  end

  // Slice data needs no reset: it is always fully rewritten before being emitted
  always_ff @(posedge clk) begin
    if (wr_en) slice_mem[in_cnt_q] <= in_slice;
  end

endmodule

`default_nettype wire

// File: tb/tb_theta_stage.sv
// ============================================================================
// tb_theta_stage : directed self-checking bench for theta_stage
// Revision       : 1.0
// ============================================================================
`default_nettype none

module tb_theta_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [24:0] in_slice = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [24:0] out_slice;
  logic [5:0]  out_index;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;

  logic [24:0] stim [64];
  logic [24:0] expv [64];

  theta_stage #(.SLICES(64), .IDX_W(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_slice  (in_slice),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_slice (out_slice),
    .out_index (out_index),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic clear_vectors();
    for (int i = 0; i < 64; i++) begin
      stim[i] = '0;
      expv[i] = '0;
    end
  endtask

  // Drive n slices from stim[], one per cycle; LOAD accepts every cycle.
  task automatic load(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("load_in_ready", {31'd0, in_ready}, 32'd1);
      check("load_out_valid", {31'd0, out_valid}, 32'd0);
      in_valid = 1'b1;
      in_slice = stim[i];
    end
  endtask

  // Collect 64 slices; stall pattern 1,0,0,1 when stall=1; garbage on input when junk=1.
  task automatic emit(input bit stall, input bit junk);
    int k;
    int cyc;
    logic [3:0] pat;
    k   = 0;
    cyc = 0;
    pat = 4'b1001;
    while (k < 64 && cyc < 1000) begin
      @(negedge clk);
      if (junk) begin
        in_valid = 1'b1;
        in_slice = 25'($urandom);
      end else begin
        in_valid = 1'b0;
      end
      out_ready = stall ? pat[cyc % 4] : 1'b1;
      cyc++;
      check("emit_out_valid", {31'd0, out_valid}, 32'd1);
      check("emit_in_ready", {31'd0, in_ready}, 32'd0);
      check("emit_done", {31'd0, done}, 32'd0);
      check($sformatf("emit_index_%0d", k), {26'd0, out_index}, k);
      check($sformatf("emit_slice_%0d", k), {7'd0, out_slice}, {7'd0, expv[k]});
      if (out_ready) k++;
    end
    check("emit_count", k, 64);
    @(negedge clk);
    out_ready = 1'b0;
    check("done_pulse", {31'd0, done}, 32'd1);
    check("done_out_valid", {31'd0, out_valid}, 32'd0);
    check("done_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    check("post_done", {31'd0, done}, 32'd0);
    check("post_in_ready", {31'd0, in_ready}, 32'd1);
    check("post_out_valid", {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_out_index", {26'd0, out_index}, 32'd0);

    // All-zero state
    clear_vectors();
    load(64);
    emit(1'b0, 1'b0);

    // Single bit a[0][0][0], with garbage on the input side during EMIT/DONE
    clear_vectors();
    stim[0] = 25'h1000000;
    expv[0] = 25'h1842108;
    expv[1] = 25'h0108421;
    load(64);
    emit(1'b0, 1'b1);

    // Wrap-around a[0][0][63] under backpressure
    clear_vectors();
    stim[63] = 25'h1000000;
    expv[63] = 25'h1842108;
    expv[0]  = 25'h0108421;
    load(64);
    emit(1'b1, 1'b0);

    // Reset after 30 slices, then a fresh all-zero load
    for (int i = 0; i < 64; i++) stim[i] = 25'($urandom) | 25'd1;
    load(30);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_out_index", {26'd0, out_index}, 32'd0);
    clear_vectors();
    load(64);
    emit(1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
